// File: rtl/move_validator_if.sv
// Purpose : request/response bundle between the game controller and move_validator.
// Latency : n/a (wiring only); every response field is a registered output of the validator.
// Backpr. : none; requests are single-cycle pulses and are evaluated on the edge that samples them.
// Ports   : new_game, PL_en, PC_en (controller -> validator);
//           board, turn, move_ack, illegal_move, illegal_code, move_count,
//           board_full, forfeit, forfeit_side (validator -> controller).
interface move_validator_if #(
   parameter int N_CELLS = 9
);
   localparam int CW = $clog2(N_CELLS + 1);

   logic                   new_game;
   logic [N_CELLS-1:0]     PL_en;
   logic [N_CELLS-1:0]     PC_en;
   logic [2*N_CELLS-1:0]   board;
   logic                   turn;
   logic                   move_ack;
   logic                   illegal_move;
   logic [1:0]             illegal_code;
   logic [CW-1:0]          move_count;
   logic                   board_full;
   logic                   forfeit;
   logic                   forfeit_side;

   // Game controller side: issues requests, observes board and status.
   modport master (
      output new_game, PL_en, PC_en,
      input  board, turn, move_ack, illegal_move, illegal_code,
             move_count, board_full, forfeit, forfeit_side
   );

   // Validator side.
   modport slave (
      input  new_game, PL_en, PC_en,
      output board, turn, move_ack, illegal_move, illegal_code,
             move_count, board_full, forfeit, forfeit_side
   );
endinterface

// File: rtl/move_validator.sv
// Purpose : board store + move arbiter; classifies one-hot move requests, commits legal ones,
//           tracks turn, move count, board-full and consecutive-illegal forfeit.
// Latency : 1 cycle from request edge to board/turn/count/ack/illegal update.
// Backpr. : none; one request per cycle, held requests are re-evaluated every cycle.
// Ports   : clk, reset (sync, active-high), bus (move_validator_if.slave) carrying
//           new_game/PL_en/PC_en in and board/turn/pulses/status out.
module move_validator #(
   parameter int N_CELLS      = 9,
   parameter int STRIKE_LIMIT = 3
) (
   input  logic            clk,
   input  logic            reset,
   move_validator_if.slave bus
);

   localparam int CW = $clog2(N_CELLS + 1);

   localparam logic [1:0] CODE_NONE     = 2'd0;
   localparam logic [1:0] CODE_OCCUPIED = 2'd1;
   localparam logic [1:0] CODE_MALFORM  = 2'd2;
   localparam logic [1:0] CODE_WRONG    = 2'd3;

   typedef enum logic [1:0] {
      S_PLAY    = 2'd0,
      S_FULL    = 2'd1,
      S_FORFEIT = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   state_t                 state_q;
   logic [2*N_CELLS-1:0]   board_q;
   logic                   turn_q;
   logic                   ack_q;
   logic                   ill_q;
   logic [1:0]             code_q;
   logic [CW-1:0]          count_q;
   logic [3:0]             strike_q;
   logic                   fside_q;

   // ------------------------------------------------------------------
   // Request classification (next-state candidates)
   // ------------------------------------------------------------------
   logic                   pl_act;
   logic                   pc_act;
   logic                   req;
   logic [N_CELLS-1:0]     sel;
   logic [N_CELLS-1:0]     occ;
   logic                   malformed;
   logic                   wrong_turn;
   logic                   occupied;
   logic [1:0]             code_d;
   logic [2*N_CELLS-1:0]   board_d;
   logic [CW-1:0]          count_d;
   logic [3:0]             strike_d;

   always_comb begin
      pl_act = |bus.PL_en;
      pc_act = |bus.PC_en;
      req    = pl_act | pc_act;

      // When both buses are active the request is malformed regardless of
      // which one is selected here, so picking PL_en first is harmless.
      sel = pl_act ? bus.PL_en : bus.PC_en;

      for (int i = 0; i < N_CELLS; i++) begin
         occ[i] = |board_q[2*i +: 2];
      end

      // x & (x-1) clears the lowest set bit; nonzero result means >1 bit set.
      malformed  = (pl_act && pc_act) ||
                   (req && ((sel & (sel - N_CELLS'(1))) != '0));
      // Player owns turn 0, computer owns turn 1.
      wrong_turn = pl_act ? turn_q : ~turn_q;
      occupied   = |(sel & occ);

      code_d = CODE_NONE;
      if (malformed) begin
         code_d = CODE_MALFORM;
      end else if (wrong_turn) begin
         code_d = CODE_WRONG;
      end else if (occupied) begin
         code_d = CODE_OCCUPIED;
      end

      board_d = board_q;
      for (int i = 0; i < N_CELLS; i++) begin
         if (sel[i]) begin
            board_d[2*i +: 2] = pl_act ? 2'b01 : 2'b10;
         end
      end

      count_d  = count_q + CW'(1);
      strike_d = strike_q + 4'd1;
   end

   // ------------------------------------------------------------------
   // Game FSM and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset || bus.new_game) begin
         // new_game outranks any same-cycle request; the request is dropped.
         state_q  <= S_PLAY;
         board_q  <= '0;
         turn_q   <= 1'b0;
         ack_q    <= 1'b0;
         ill_q    <= 1'b0;
         code_q   <= CODE_NONE;
         count_q  <= '0;
         strike_q <= 4'd0;
         fside_q  <= 1'b0;
      end else begin
         ack_q  <= 1'b0;
         ill_q  <= 1'b0;
         code_q <= CODE_NONE;

         case (state_q)
            S_PLAY: begin
               if (req) begin
                  if (code_d == CODE_NONE) begin
                     board_q  <= board_d;
                     count_q  <= count_d;
                     turn_q   <= ~turn_q;
                     strike_q <= 4'd0;
                     ack_q    <= 1'b1;
                     if (count_d == CW'(N_CELLS)) begin
                        state_q <= S_FULL;
                     end
                  end else begin
                     ill_q  <= 1'b1;
                     code_q <= code_d;
                     // Wrong-turn attempts are reported but do not count as
                     // strikes, and they leave the strike count untouched.
                     if (code_d != CODE_WRONG) begin
                        strike_q <= strike_d;
                        if (strike_d >= 4'(STRIKE_LIMIT)) begin
                           state_q <= S_FORFEIT;
                           fside_q <= turn_q;
                        end
                     end
                  end
               end
            end
            // FULL and FORFEIT are terminal until reset/new_game; requests are ignored.
            S_FULL, S_FORFEIT: begin
               state_q <= state_q;
            end
            default: begin
               state_q <= S_PLAY;
            end
         endcase
      end
   end

   assign bus.board        = board_q;
   assign bus.turn         = turn_q;
   assign bus.move_ack     = ack_q;
   assign bus.illegal_move = ill_q;
   assign bus.illegal_code = code_q;
   assign bus.move_count   = count_q;
   assign bus.board_full   = (state_q == S_FULL);
   assign bus.forfeit      = (state_q == S_FORFEIT);
   assign bus.forfeit_side = fside_q;

endmodule

// File: tb/tb_move_validator.sv
// Purpose : directed table-driven check of move_validator (9 cells / 3 strikes) plus a
//           hand-written sequence on a 16-cell / 1-strike instance.
// Latency : each vector is applied for one cycle and checked 1 time unit after the sampling edge.
// Backpr. : none.
module tb_move_validator;

   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   move_validator_if #(.N_CELLS(9))  bus9 ();
   move_validator_if #(.N_CELLS(16)) bus16 ();

   move_validator #(.N_CELLS(9), .STRIKE_LIMIT(3)) dut9 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus9)
   );

   move_validator #(.N_CELLS(16), .STRIKE_LIMIT(1)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   int total;
   int bad;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        ng;
      logic [8:0]  pl;
      logic [8:0]  pc;
      logic        ack;
      logic        ill;
      logic [1:0]  code;
      logic [17:0] board;
      logic        turn;
      logic [3:0]  cnt;
      logic        full;
      logic        forf;
      logic        fside;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic ng, input logic [8:0] pl,
                               input logic [8:0] pc, input logic ack, input logic ill,
                               input logic [1:0] code, input logic [17:0] board,
                               input logic turn, input logic [3:0] cnt, input logic full,
                               input logic forf, input logic fside);
      vec_t v;
      v.rst = rst; v.ng = ng; v.pl = pl; v.pc = pc;
      v.ack = ack; v.ill = ill; v.code = code; v.board = board;
      v.turn = turn; v.cnt = cnt; v.full = full; v.forf = forf; v.fside = fside;
      return v;
   endfunction

   task automatic check9(input string tag, input vec_t v);
      chk({tag, " ack"},   64'(bus9.move_ack),     64'(v.ack));
      chk({tag, " ill"},   64'(bus9.illegal_move), 64'(v.ill));
      chk({tag, " code"},  64'(bus9.illegal_code), 64'(v.code));
      chk({tag, " board"}, 64'(bus9.board),        64'(v.board));
      chk({tag, " turn"},  64'(bus9.turn),         64'(v.turn));
      chk({tag, " cnt"},   64'(bus9.move_count),   64'(v.cnt));
      chk({tag, " full"},  64'(bus9.board_full),   64'(v.full));
      chk({tag, " forf"},  64'(bus9.forfeit),      64'(v.forf));
      chk({tag, " fside"}, 64'(bus9.forfeit_side), 64'(v.fside));
   endtask

   task automatic step16(input logic ng, input logic [15:0] pl, input logic [15:0] pc);
      @(negedge clk);
      bus16.new_game = ng;
      bus16.PL_en    = pl;
      bus16.PC_en    = pc;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp16;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus9.new_game  = 1'b0; bus9.PL_en  = '0; bus9.PC_en  = '0;
      bus16.new_game = 1'b0; bus16.PL_en = '0; bus16.PC_en = '0;

      //              rst ng  PL      PC      ack ill code board     t  cnt full forf fside
      // Basic moves, illegal codes, strike bookkeeping.
      tbl.push_back(mk(0, 0, 9'h001, 9'h000, 1, 0, 0, 18'h00001, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h000, 9'h002, 1, 0, 0, 18'h00009, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h002, 9'h000, 0, 1, 1, 18'h00009, 0, 2, 0, 0, 0)); // occupied, s=1
      tbl.push_back(mk(0, 0, 9'h000, 9'h000, 0, 0, 0, 18'h00009, 0, 2, 0, 0, 0)); // idle
      tbl.push_back(mk(0, 0, 9'h003, 9'h000, 0, 1, 2, 18'h00009, 0, 2, 0, 0, 0)); // not one-hot, s=2
      tbl.push_back(mk(0, 0, 9'h000, 9'h004, 0, 1, 3, 18'h00009, 0, 2, 0, 0, 0)); // wrong turn, s stays 2
      tbl.push_back(mk(0, 0, 9'h004, 9'h000, 1, 0, 0, 18'h00019, 1, 3, 0, 0, 0)); // legal, s=0
      tbl.push_back(mk(0, 0, 9'h000, 9'h008, 1, 0, 0, 18'h00099, 0, 4, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h001, 9'h000, 0, 1, 1, 18'h00099, 0, 4, 0, 0, 0)); // s=1
      tbl.push_back(mk(0, 0, 9'h002, 9'h000, 0, 1, 1, 18'h00099, 0, 4, 0, 0, 0)); // s=2
      tbl.push_back(mk(0, 0, 9'h010, 9'h010, 0, 1, 2, 18'h00099, 0, 4, 0, 1, 0)); // both buses, s=3 -> forfeit
      tbl.push_back(mk(0, 0, 9'h010, 9'h000, 0, 0, 0, 18'h00099, 0, 4, 0, 1, 0)); // ignored
      tbl.push_back(mk(0, 1, 9'h000, 9'h000, 0, 0, 0, 18'h00000, 0, 0, 0, 0, 0)); // new_game
      // Nine alternating legal moves -> FULL.
      tbl.push_back(mk(0, 0, 9'h001, 9'h000, 1, 0, 0, 18'h00001, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h000, 9'h002, 1, 0, 0, 18'h00009, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h004, 9'h000, 1, 0, 0, 18'h00019, 1, 3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h000, 9'h008, 1, 0, 0, 18'h00099, 0, 4, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h010, 9'h000, 1, 0, 0, 18'h00199, 1, 5, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h000, 9'h020, 1, 0, 0, 18'h00999, 0, 6, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h040, 9'h000, 1, 0, 0, 18'h01999, 1, 7, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h000, 9'h080, 1, 0, 0, 18'h09999, 0, 8, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h100, 9'h000, 1, 0, 0, 18'h19999, 1, 9, 1, 0, 0)); // full on 9th ack
      tbl.push_back(mk(0, 0, 9'h000, 9'h001, 0, 0, 0, 18'h19999, 1, 9, 1, 0, 0)); // ignored
      tbl.push_back(mk(0, 1, 9'h000, 9'h000, 0, 0, 0, 18'h00000, 0, 0, 0, 0, 0));
      // new_game / reset together with a legal request.
      tbl.push_back(mk(0, 0, 9'h001, 9'h000, 1, 0, 0, 18'h00001, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 9'h000, 9'h002, 0, 0, 0, 18'h00000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h001, 9'h000, 1, 0, 0, 18'h00001, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 9'h000, 9'h002, 0, 0, 0, 18'h00000, 0, 0, 0, 0, 0));
      // Held requests turn into wrong-turn on their second cycle.
      tbl.push_back(mk(0, 0, 9'h001, 9'h000, 1, 0, 0, 18'h00001, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h001, 9'h000, 0, 1, 3, 18'h00001, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h000, 9'h002, 1, 0, 0, 18'h00009, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h000, 9'h002, 0, 1, 3, 18'h00009, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 9'h002, 9'h000, 0, 1, 1, 18'h00009, 0, 2, 0, 0, 0));

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check9("reset", mk(0, 0, 9'h0, 9'h0, 0, 0, 0, 18'h0, 0, 0, 0, 0, 0));
      chk("reset16 board", 64'(bus16.board),      64'h0);
      chk("reset16 cnt",   64'(bus16.move_count), 64'h0);
      chk("reset16 forf",  64'(bus16.forfeit),    64'h0);

      foreach (tbl[i]) begin
         @(negedge clk);
         reset          = tbl[i].rst;
         bus9.new_game  = tbl[i].ng;
         bus9.PL_en     = tbl[i].pl;
         bus9.PC_en     = tbl[i].pc;
         @(posedge clk);
         #1;
         check9($sformatf("v%0d", i), tbl[i]);
      end
      @(negedge clk);
      reset = 1'b0;
      bus9.new_game = 1'b0; bus9.PL_en = '0; bus9.PC_en = '0;

      // 16-cell, single-strike instance.
      step16(1'b1, 16'h0000, 16'h0000);
      step16(1'b0, 16'h0001, 16'h0000);
      chk("n16 first ack",  64'(bus16.move_ack),   64'h1);
      chk("n16 first turn", 64'(bus16.turn),       64'h1);
      step16(1'b0, 16'h0000, 16'h0001);
      chk("n16 occ ill",    64'(bus16.illegal_move), 64'h1);
      chk("n16 occ code",   64'(bus16.illegal_code), 64'h1);
      chk("n16 forfeit",    64'(bus16.forfeit),      64'h1);
      chk("n16 fside",      64'(bus16.forfeit_side), 64'h1);
      step16(1'b0, 16'h0000, 16'h0002);
      chk("n16 forf ignore", 64'(bus16.move_ack),    64'h0);
      step16(1'b1, 16'h0000, 16'h0000);
      chk("n16 ng forf",    64'(bus16.forfeit),      64'h0);
      chk("n16 ng fside",   64'(bus16.forfeit_side), 64'h0);

      exp16 = '0;
      for (int k = 0; k < 16; k++) begin
         if (k % 2 == 0) begin
            step16(1'b0, 16'(1) << k, 16'h0000);
            exp16 = exp16 | (32'h1 << (2 * k));
         end else begin
            step16(1'b0, 16'h0000, 16'(1) << k);
            exp16 = exp16 | (32'h2 << (2 * k));
         end
         chk($sformatf("n16 m%0d ack", k), 64'(bus16.move_ack), 64'h1);
         if (k == 14) begin
            chk("n16 not full yet", 64'(bus16.board_full), 64'h0);
         end
      end
      chk("n16 board", 64'(bus16.board),      64'(exp16));
      chk("n16 cnt",   64'(bus16.move_count), 64'd16);
      chk("n16 full",  64'(bus16.board_full), 64'h1);
      step16(1'b0, 16'h0001, 16'h0000);
      chk("n16 full ignore ack", 64'(bus16.move_ack),     64'h0);
      chk("n16 full ignore ill", 64'(bus16.illegal_move), 64'h0);
      step16(1'b0, 16'h0000, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/move_validator.md
# move_validator

Parametrised, registered move arbiter and board store for the game datapath. It holds the N-cell board state and accepts one-hot move requests from the player and computer sides. Each request is checked for occupancy, malformation and turn order. Legal moves are committed; illegal ones are reported with a cause code. Turn order, move count, board-full and consecutive-illegal forfeit are tracked, and the block feeds the win checker and display logic downstream.

## Interface
Parameters:
- N_CELLS, 9: number of board cells (3x3 default; any value 2..64).
- STRIKE_LIMIT, 3: consecutive illegal attempts that forfeit the game (1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- new_game  input  1  synchronous game clear, same effect as reset.
- PL_en  input  N_CELLS  player move request, one-hot cell select, sampled every edge.
- PC_en  input  N_CELLS  computer move request, one-hot cell select.
- board  output  2*N_CELLS  cell i at [2i+1:2i]: 00 empty, 01 player, 10 computer.
- turn  output  1  0 = player to move, 1 = computer to move.
- move_ack  output  1  one-cycle pulse, legal move committed.
- illegal_move  output  1  one-cycle pulse, request rejected.
- illegal_code  output  2  cause, valid with illegal_move: 1 occupied, 2 malformed, 3 wrong turn; 0 otherwise.
- move_count  output  $clog2(N_CELLS+1)  committed moves this game.
- board_full  output  1  high in state FULL.
- forfeit  output  1  high in state FORFEIT.
- forfeit_side  output  1  side that forfeited (turn value at forfeit); 0 outside FORFEIT.

## Operation
- States: PLAY, FULL, FORFEIT. Reset/new_game → PLAY.
- A request exists in a cycle when PL_en or PC_en is nonzero. Only PLAY evaluates requests; in FULL/FORFEIT requests are ignored with no ack and no illegal.
- Classification, priority high to low:
  - malformed (2): both buses nonzero, or the active bus not one-hot;
  - wrong turn (3): active bus belongs to the side not on turn;
  - occupied (1): selected cell not 00;
  - else legal.
- Legal move:
  - write the mover's code into the cell;
  - move_count+1;
  - toggle turn;
  - clear strike counter;
  - pulse move_ack.
- Illegal move: board, turn and move_count unchanged; pulse illegal_move with code.
  - Codes 1 and 2 increment the internal strike counter.
  - Code 3 does not.
  - When the counter reaches STRIKE_LIMIT: → FORFEIT, forfeit_side = turn.
- Legal move bringing move_count to N_CELLS → FULL (same edge as the board write).
- FULL and FORFEIT hold until reset or new_game.
- new_game has priority over a same-cycle request; the request is dropped.
- Held requests are re-evaluated each cycle. Upstream must pulse. A held legal request becomes wrong-turn on its second cycle.

## Timing
- Request sampled at edge k. Board, turn, move_count, move_ack/illegal_move/illegal_code and state all visible after edge k; latency 1 cycle. One request per cycle throughput.
- Reset/new_game values:
  - board 0, turn 0, move_ack 0, illegal_move 0, illegal_code 0;
  - move_count 0, board_full 0, forfeit 0, forfeit_side 0;
  - strike counter 0.
- move_ack and illegal_move are mutually exclusive and never asserted for two cycles from one single-cycle request.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then PL_en=9'h001 one cycle → next cycle move_ack=1, board[1:0]=01, turn=1, move_count=1; PC_en=9'h002 → board[3:2]=10, turn=0, move_count=2.
- After the above, PL_en=9'h002 → illegal_move=1, code 1, board unchanged. Three such attempts in a row (STRIKE_LIMIT=3) → forfeit=1, forfeit_side=0; further requests produce no pulses.
- PL_en=9'h003 → code 2. PL_en and PC_en both nonzero → code 2. PC_en while turn=0 → code 3, strike counter not incremented; then a legal move and the counter clears.
- Nine alternating legal moves → board_full=1 on the ninth ack edge, move_count=9. A tenth request is ignored. new_game → all outputs at reset values.
- new_game asserted together with a legal request mid-game → board cleared, no move_ack, move_count=0. Reset mid-game behaves identically.
- Re-run with N_CELLS=16, STRIKE_LIMIT=1: a single occupied-cell attempt forfeits. Sixteen legal moves → FULL with move_count=16 (5-bit counter).
